// File: rtl/use_stream_pkg.sv
// Shared types and helpers for the USE stream packer: FSM states, default
// geometry and the beat-count helper.
package use_stream_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EMIT_HDR = 2'd1,
    EMIT     = 2'd2
  } packer_state_t;

  localparam int unsigned DEF_DATA_BUS_WIDTH_BYTES   = 8;
  localparam int unsigned DEF_MAX_UNCOMPRESSED_BYTES = 34;

  function automatic int unsigned beat_count(input int unsigned len, input int unsigned w);
    return (len + w - 1) / w;
  endfunction

endpackage

// File: rtl/use_stream_packer_if.sv
// AXI4-Stream bundle carrying serialised USE records out of the packer.
interface use_stream_packer_if #(
  parameter int unsigned DATA_BUS_WIDTH_BYTES = use_stream_pkg::DEF_DATA_BUS_WIDTH_BYTES
);
  logic [DATA_BUS_WIDTH_BYTES*8-1:0] tdata;
  logic [DATA_BUS_WIDTH_BYTES-1:0]   tkeep;
  logic                              tlast;
  logic                              tvalid;
  logic                              tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/use_beat_slicer.sv
// Combinational beat extractor: selects one W-byte window of the record
// buffer and masks lanes at or beyond the record length.
module use_beat_slicer #(
  parameter int unsigned W      = 8,
  parameter int unsigned MAX    = 34,
  parameter int unsigned LEN_W  = 6,
  parameter int unsigned BEAT_W = 3
) (
  input  logic [MAX-1:0][7:0] rec_buf,
  input  logic [LEN_W-1:0]    len,
  input  logic [BEAT_W-1:0]   beat,
  output logic [W*8-1:0]      data,
  output logic [W-1:0]        keep
);
  localparam int unsigned NB    = (MAX + W - 1) / W;
  localparam int unsigned PAD_W = NB * W * 8;

  logic [PAD_W-1:0] padded;
  logic [W*8-1:0]   lane;

  // Pad to whole beats so the window shift never reads past the buffer.
  assign padded = PAD_W'(rec_buf);
  assign lane   = (W*8)'(padded >> (32'(beat) * (W * 8)));

  always_comb begin
    data = '0;
    keep = '0;
    for (int unsigned j = 0; j < W; j++) begin
      if (32'(beat) * W + j < 32'(len)) begin
        keep[j]        = 1'b1;
        data[j*8 +: 8] = lane[j*8 +: 8];
      end
    end
  end
endmodule

// File: rtl/use_stream_packer.sv
// Round-robin USE record capture from the StreamElement ring, serialised onto
// AXI4-Stream. Optional length header beat: USE_PACKER_LENGTH_HEADER_EN.
module use_stream_packer
  import use_stream_pkg::*;
#(
  parameter int unsigned NUM_ELEMENTS           = 4,
  parameter int unsigned DATA_BUS_WIDTH_BYTES   = DEF_DATA_BUS_WIDTH_BYTES,
  parameter int unsigned MAX_UNCOMPRESSED_BYTES = DEF_MAX_UNCOMPRESSED_BYTES,
  parameter int unsigned LEN_W                  = $clog2(MAX_UNCOMPRESSED_BYTES)
) (
  input  logic                                                   clk,
  input  logic                                                   reset_n,
  input  logic [NUM_ELEMENTS-1:0][MAX_UNCOMPRESSED_BYTES-1:0][7:0] useStreamIn,
  input  logic [NUM_ELEMENTS-1:0][LEN_W-1:0]                     useByteLengthIn,
  input  logic [NUM_ELEMENTS-1:0]                                useLastIn,
  output logic [NUM_ELEMENTS-1:0]                                useDataTaken,
  use_stream_packer_if.master                                    m_axis,
  output logic [15:0]                                            recordCount,
  output logic                                                   lengthErr
);
  localparam int unsigned W         = DATA_BUS_WIDTH_BYTES;
  localparam int unsigned MAX_BEATS = beat_count(MAX_UNCOMPRESSED_BYTES, W);
  localparam int unsigned BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int unsigned ELEM_W    = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_UNCOMPRESSED_BYTES);

  packer_state_t                           state_q, state_d;
  logic [ELEM_W-1:0]                       cur_elem;
  logic [MAX_UNCOMPRESSED_BYTES-1:0][7:0]  rec_buf;
  logic [LEN_W-1:0]                        rec_len;
  logic                                    rec_last;
  logic [BEAT_W-1:0]                       beat;
  logic [NUM_ELEMENTS-1:0]                 taken_q;
  logic [15:0]                             rec_count;
  logic                                    len_err;

  logic [LEN_W-1:0] in_len;
  logic             capture;
  logic             over;
  logic             last_beat;
  logic [W*8-1:0]   slice_data;
  logic [W-1:0]     slice_keep;

  assign in_len    = useByteLengthIn[cur_elem];
  assign capture   = (state_q == IDLE) && (in_len != '0);
  assign over      = in_len > MAX_LEN;
  assign last_beat = 32'(beat) == beat_count(32'(rec_len), W) - 1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
`ifdef USE_PACKER_LENGTH_HEADER_EN
          state_d = EMIT_HDR;
`else
          state_d = EMIT;
`endif
        end
      end
`ifdef USE_PACKER_LENGTH_HEADER_EN
      EMIT_HDR: if (m_axis.tready) state_d = EMIT;
`endif
      EMIT:     if (m_axis.tready && last_beat) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_elem  <= '0;
      rec_len   <= '0;
      rec_last  <= 1'b0;
      beat      <= '0;
      taken_q   <= '0;
      rec_count <= '0;
      len_err   <= 1'b0;
    end else begin
      taken_q <= '0;
      if (capture) begin
        taken_q  <= NUM_ELEMENTS'(1) << cur_elem;
        rec_len  <= over ? MAX_LEN : in_len;
        rec_last <= useLastIn[cur_elem];
        beat     <= '0;
        if (over) len_err <= 1'b1;
      end
      if (state_q == EMIT && m_axis.tready) begin
        if (last_beat) begin
          rec_count <= rec_count + 16'd1;
          cur_elem  <= (cur_elem == ELEM_W'(NUM_ELEMENTS - 1)) ? '0 : cur_elem + 1'b1;
        end else begin
          beat <= beat + 1'b1;
        end
      end
    end
  end

  // Payload storage needs no reset: it is only observed after a capture.
  always_ff @(posedge clk) begin
    if (capture) rec_buf <= useStreamIn[cur_elem];
  end

  use_beat_slicer #(
    .W      (W),
    .MAX    (MAX_UNCOMPRESSED_BYTES),
    .LEN_W  (LEN_W),
    .BEAT_W (BEAT_W)
  ) u_slicer (
    .rec_buf (rec_buf),
    .len     (rec_len),
    .beat    (beat),
    .data    (slice_data),
    .keep    (slice_keep)
  );

  always_comb begin
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = '0;
    m_axis.tkeep  = '0;
    m_axis.tlast  = 1'b0;
    unique case (state_q)
`ifdef USE_PACKER_LENGTH_HEADER_EN
      EMIT_HDR: begin
        m_axis.tvalid       = 1'b1;
        m_axis.tkeep        = '1;
        m_axis.tdata[7:0]   = 8'(rec_len);
        m_axis.tdata[15:8]  = 8'(cur_elem);
      end
`endif
      EMIT: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = slice_data;
        m_axis.tkeep  = slice_keep;
        m_axis.tlast  = rec_last && last_beat;
      end
      default: ;
    endcase
  end

  assign useDataTaken = taken_q;
  assign recordCount  = rec_count;
  assign lengthErr    = len_err;
endmodule

// File: tb/tb_use_stream_packer.sv
// Directed bench for use_stream_packer: capture order, beat slicing, stalls,
// length clamp and async reset; follows USE_PACKER_LENGTH_HEADER_EN if defined.
module tb_use_stream_packer;
  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic [3:0][33:0][7:0]  stream;
  logic [3:0][5:0]        lens;
  logic [3:0]             lasts;
  logic [3:0]             taken;
  logic [15:0]            rec_count;
  logic                   len_err;
  int                     checks = 0;
  int                     passes = 0;

  use_stream_packer_if #(.DATA_BUS_WIDTH_BYTES(8)) axis ();

  use_stream_packer #(
    .NUM_ELEMENTS           (4),
    .DATA_BUS_WIDTH_BYTES   (8),
    .MAX_UNCOMPRESSED_BYTES (34)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .useStreamIn     (stream),
    .useByteLengthIn (lens),
    .useLastIn       (lasts),
    .useDataTaken    (taken),
    .m_axis          (axis),
    .recordCount     (rec_count),
    .lengthErr       (len_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int e, input int i);
    return 8'(e * 64 + i + 1);
  endfunction

  function automatic logic [63:0] exp_beat(input int e, input int len, input int k);
    logic [63:0] r = '0;
    for (int j = 0; j < 8; j++)
      if (k * 8 + j < len) r[j*8 +: 8] = pat(e, k * 8 + j);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
  endtask

  task automatic await_taken(input int e);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (taken != 4'b0) break;
    end
    chk("taken_onehot", 64'(taken), 64'(4'b0001 << e));
    lens[e] = '0;
    chk("tvalid_after_capture", 64'(axis.tvalid), 64'(1));
  endtask

  task automatic drain(input int e, input int clen, input logic last, input int nb,
                       input logic [4:0][7:0] keeps, input int stall,
                       input logic [15:0] exp_count);
    int hdr;
    logic [63:0] d;
    logic [7:0]  kp;
    logic        l;
`ifdef USE_PACKER_LENGTH_HEADER_EN
    hdr = 1;
`else
    hdr = 0;
`endif
    await_taken(e);
    for (int b = 0; b < nb + hdr; b++) begin
      if (b < hdr) begin
        d  = {48'h0, 8'(e), 8'(clen)};
        kp = 8'hFF;
        l  = 1'b0;
      end else begin
        d  = exp_beat(e, clen, b - hdr);
        kp = keeps[b - hdr];
        l  = last && (b - hdr == nb - 1);
      end
      chk("tdata", axis.tdata, d);
      chk("tkeep", 64'(axis.tkeep), 64'(kp));
      chk("tlast", 64'(axis.tlast), 64'(l));
      if (b == 0 && stall > 0) begin
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("hold_tdata", axis.tdata, d);
          chk("hold_tkeep", 64'(axis.tkeep), 64'(kp));
          chk("hold_tlast", 64'(axis.tlast), 64'(l));
          chk("hold_count", 64'(rec_count), 64'(exp_count - 16'd1));
        end
        axis.tready = 1'b1;
      end
      @(negedge clk);
      if (b == 0) chk("taken_single_cycle", 64'(taken), 64'(0));
    end
    chk("bubble_tvalid", 64'(axis.tvalid), 64'(0));
    chk("record_count", 64'(rec_count), 64'(exp_count));
  endtask

  initial begin
    for (int e = 0; e < 4; e++)
      for (int i = 0; i < 34; i++) stream[e][i] = pat(e, i);
    lens        = '0;
    lasts       = '0;
    axis.tready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tvalid", 64'(axis.tvalid), 64'(0));
    chk("rst_tdata", axis.tdata, 64'(0));
    chk("rst_tkeep", 64'(axis.tkeep), 64'(0));
    chk("rst_tlast", 64'(axis.tlast), 64'(0));
    chk("rst_taken", 64'(taken), 64'(0));
    chk("rst_count", 64'(rec_count), 64'(0));
    chk("rst_lenerr", 64'(len_err), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // Element 0, len 27: FF FF FF 07, tlast on beat 3
    lens[0] = 6'd27; lasts[0] = 1'b1;
    drain(0, 27, 1'b1, 4, {8'h00, 8'h07, 8'hFF, 8'hFF, 8'hFF}, 0, 16'd1);

    // Element 2 ready first, but element 1 is next in the ring
    lens[2] = 6'd20; lasts[2] = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_out_of_turn_taken", 64'(taken), 64'(0));
    chk("no_out_of_turn_valid", 64'(axis.tvalid), 64'(0));
    lens[1] = 6'd20; lasts[1] = 1'b1;
    drain(1, 20, 1'b1, 3, {8'h00, 8'h00, 8'h0F, 8'hFF, 8'hFF}, 0, 16'd2);
    drain(2, 20, 1'b0, 3, {8'h00, 8'h00, 8'h0F, 8'hFF, 8'hFF}, 0, 16'd3);

    // Element 3, len 16 with 5 stalled cycles on the first beat
    lens[3] = 6'd16; lasts[3] = 1'b1;
    axis.tready = 1'b0;
    drain(3, 16, 1'b1, 2, {8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF}, 5, 16'd4);

    // Element 0, len 40 clamps to 34: FF x4, 03
    lens[0] = 6'd40; lasts[0] = 1'b1;
    drain(0, 34, 1'b1, 5, {8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0, 16'd5);
    chk("lenerr_set", 64'(len_err), 64'(1));
    lens[1] = 6'd9; lasts[1] = 1'b0;
    drain(1, 9, 1'b0, 2, {8'h00, 8'h00, 8'h00, 8'h01, 8'hFF}, 0, 16'd6);
    chk("lenerr_sticky", 64'(len_err), 64'(1));

    // Element 2, len 27: reset during beat 2
    lens[2] = 6'd27; lasts[2] = 1'b1;
    await_taken(2);
`ifdef USE_PACKER_LENGTH_HEADER_EN
    @(negedge clk);
`endif
    repeat (2) @(negedge clk);
    chk("beat2_tdata", axis.tdata, exp_beat(2, 27, 2));
    chk("beat2_tkeep", 64'(axis.tkeep), 64'(8'hFF));
    reset_n = 1'b0;
    #1;
    chk("async_tvalid", 64'(axis.tvalid), 64'(0));
    chk("async_count", 64'(rec_count), 64'(0));
    chk("async_lenerr", 64'(len_err), 64'(0));
    chk("async_tkeep", 64'(axis.tkeep), 64'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Both 0 and 1 ready: element 0 must go first after reset
    lens[0] = 6'd5; lasts[0] = 1'b0;
    lens[1] = 6'd3; lasts[1] = 1'b1;
    drain(0, 5, 1'b0, 1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h1F}, 0, 16'd1);
    drain(1, 3, 1'b1, 1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h07}, 0, 16'd2);

    // Elements 2 and 3, len 9: FF 01
    lens[2] = 6'd9; lasts[2] = 1'b0;
    drain(2, 9, 1'b0, 2, {8'h00, 8'h00, 8'h00, 8'h01, 8'hFF}, 0, 16'd3);
    lens[3] = 6'd9; lasts[3] = 1'b1;
    drain(3, 9, 1'b1, 2, {8'h00, 8'h00, 8'h00, 8'h01, 8'hFF}, 0, 16'd4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
